// File: rtl/adc_readout_seq_pkg.sv
// Shared types for the ADC readout sequencer.
// Sample geometry and FSM state encoding.
package adc_readout_pkg;

    localparam int SAMPLE_W       = 12;
    localparam int BYTES_PER_PAIR = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        READY,
        DONE
    } readout_state_t;

endpackage

// File: rtl/adc_readout_seq_if.sv
// Sample FIFO read port seen by the readout sequencer.
// master = sequencer side, slave = FIFO side.
interface adc_readout_seq_if
    import adc_readout_pkg::*;
#(
    parameter int W = SAMPLE_W
);
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/adc_readout_seq.sv
// Pulls samples from the ADC FIFO and packs them into a byte
// stream (8-bit or 12-bit packed) for the USB data register.
module adc_readout_seq
    import adc_readout_pkg::*;
#(
    parameter int pSAMPLE_WIDTH = 12,
    parameter int pCOUNT_WIDTH  = 20
) (
    input  logic                    clk_usb,
    input  logic                    reset,
    input  logic                    I_start,
    input  logic                    I_low_res,
    input  logic [pCOUNT_WIDTH-1:0] I_num_samples,
    adc_readout_seq_if.master       fifo,
    input  logic                    I_byte_req,
    output logic [7:0]              O_byte,
    output logic                    O_byte_valid,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_underflow
);

    readout_state_t state, state_n;

    logic [pSAMPLE_WIDTH-1:0] dout;
    logic [pCOUNT_WIDTH-1:0]  remaining;
    logic                     low_res;
    logic                     phase;
    logic                     stash_pend;
    logic                     final_byte;
    logic [3:0]               nib;
    logic [7:0]               stash;
    logic                     start_ok;
    logic                     nib_pend;
    logic                     rem_zero;

    assign dout     = fifo.fifo_dout;
    assign start_ok = I_start && (state == IDLE || state == DONE);
    // phase=1 means a low nibble is held waiting for its partner sample
    assign nib_pend = !low_res && phase;
    assign rem_zero = (remaining == '0);

    always_ff @(posedge clk_usb) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (I_start)
                    state_n = (I_num_samples == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (!fifo.fifo_empty) state_n = LATCH;
            end
            LATCH: state_n = READY;
            READY: begin
                if (I_byte_req && !stash_pend) begin
                    if (final_byte)    state_n = DONE;
                    else if (!rem_zero) state_n = FETCH;
                    else if (!nib_pend) state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        fifo.fifo_rd_en = (state == FETCH) && !fifo.fifo_empty;
        O_byte_valid    = (state == READY);
        O_busy          = (state == FETCH) || (state == LATCH) ||
                          (state == READY);
        O_done          = (state == DONE);
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            remaining   <= '0;
            low_res     <= 1'b0;
            phase       <= 1'b0;
            stash_pend  <= 1'b0;
            final_byte  <= 1'b0;
            nib         <= 4'h0;
            stash       <= 8'h00;
            O_byte      <= 8'h00;
            O_underflow <= 1'b0;
        end else begin
            if (start_ok) begin
                low_res     <= I_low_res;
                remaining   <= I_num_samples;
                phase       <= 1'b0;
                stash_pend  <= 1'b0;
                final_byte  <= 1'b0;
                O_underflow <= 1'b0;
            end else if (I_byte_req && state != READY) begin
                O_underflow <= 1'b1;
            end

            if (state == LATCH) begin
                if (!rem_zero) remaining <= remaining - 1'b1;
                if (low_res) begin
                    O_byte <= dout[11:4];
                end else if (!phase) begin
                    O_byte <= dout[11:4];
                    nib    <= dout[3:0];
                    phase  <= 1'b1;
                end else begin
                    O_byte     <= {nib, dout[11:8]};
                    stash      <= dout[7:0];
                    stash_pend <= 1'b1;
                end
            end

            if (state == READY && I_byte_req) begin
                if (stash_pend) begin
                    O_byte     <= stash;
                    stash_pend <= 1'b0;
                    phase      <= 1'b0;
                end else if (!final_byte && nib_pend && rem_zero) begin
                    O_byte     <= {nib, 4'h0};
                    final_byte <= 1'b1;
                end
            end
        end
    end

endmodule
